// File: rtl/lab2_sweep_ctrl.sv
// Truth-table sweeper: walks a small combinational circuit through every input
// vector, settles, samples dut_out and packs the results. Optional golden-table
// compare is enabled with `define LAB2_SWEEP_CHECK_EN.
//
// Handshake: start is a level request sampled on each rising clk edge and
// accepted only while idle (busy low); busy covers the whole sweep including
// the one-cycle done pulse, and a start seen while busy is dropped, not queued.
module lab2_sweep_ctrl #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dut_out,
`ifdef LAB2_SWEEP_CHECK_EN
  input  logic [2**WIDTH-1:0]   expected,
  output logic                  mismatch,
  output logic [WIDTH-1:0]      first_bad,
`endif
  output logic [WIDTH-1:0]      dut_in,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   truth_table
);

  localparam int NVEC = 1 << WIDTH;
  localparam int IW   = WIDTH + 1;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IW-1:0] LAST      = IW'(NVEC - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clear_tt;
  logic            sample_en;
  logic [WIDTH-1:0] dut_in_d;
  logic            busy_d;
  logic            done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dut_in  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dut_in  <= dut_in_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    clear_tt  = 1'b0;
    sample_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_HOLD;
          idx_d    = '0;
          cnt_d    = SETTLE_M1;
          clear_tt = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        sample_en = 1'b1;
        // Compare against the last vector before incrementing so dut_in never wraps.
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          cnt_d   = SETTLE_M1;
          state_d = S_HOLD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from next-state values so they align with the state.
    dut_in_d = (state_d == S_IDLE) ? '0 : idx_d[WIDTH-1:0];
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truth_table <= '0;
    end else if (clear_tt) begin
      truth_table <= '0;
    end else if (sample_en) begin
      truth_table[idx_q[WIDTH-1:0]] <= dut_out;
    end
  end

`ifdef LAB2_SWEEP_CHECK_EN
  logic [WIDTH-1:0] first_bad_d;

  // Descending scan so the lowest differing index is the one that sticks.
  always_comb begin
    first_bad_d = '0;
    for (int k = NVEC - 1; k >= 0; k--) begin
      if (truth_table[k] != expected[k]) begin
        first_bad_d = k[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch  <= 1'b0;
      first_bad <= '0;
    end else if (clear_tt) begin
      mismatch  <= 1'b0;
      first_bad <= '0;
    end else if (state_q == S_DONE) begin
      mismatch  <= (truth_table != expected);
      first_bad <= first_bad_d;
    end
  end
`endif

endmodule
